eci_credit_arbiter: RTL

- Round-robin arbiter that shares one ECI request port between N_CH requesters.
- Enforces a per-channel cap on outstanding completion-bearing requests, using credits returned by the completion path.
- Sits between the per-channel DMA request streams and the ECI request pipeline, replacing unbounded arbitration. One channel can no longer fill the shared outstanding sequence queues.

---
 rtl/eci_credit_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/eci_credit_arbiter.sv
// Round-robin arbiter sharing one ECI request port between N_CH channels,
// capping each channel's outstanding completion-bearing requests with returned credits.
module eci_credit_arbiter #(
    parameter int N_CH     = 4,
    parameter int REQ_BITS = 96,
    parameter int CRED_MAX = 8,
    parameter int CH_BITS  = $clog2(N_CH),
    parameter int CNT_BITS = $clog2(CRED_MAX + 1)
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_CH-1:0]              s_valid,
    output logic [N_CH-1:0]              s_ready,
    input  logic [N_CH*REQ_BITS-1:0]     s_data,
    input  logic [N_CH-1:0]              s_ctl,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [REQ_BITS-1:0]          m_data,
    output logic                         m_ctl,
    output logic [CH_BITS-1:0]           m_vfid,
    input  logic                         cpl_valid,
    input  logic [CH_BITS-1:0]           cpl_vfid,
    output logic [N_CH*CNT_BITS-1:0]     credits,
    output logic                         cpl_err
);

    localparam logic [CNT_BITS-1:0] CRED_FULL = CNT_BITS'(CRED_MAX);
    localparam logic [CH_BITS:0]    N_CH_EXT  = (CH_BITS + 1)'(N_CH);
    localparam logic [CH_BITS-1:0]  LAST_CH   = CH_BITS'(N_CH - 1);

    logic [CH_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic                m_valid_q;
    logic [REQ_BITS-1:0] m_data_q;
    logic                m_ctl_q;
    logic [CH_BITS-1:0]  m_vfid_q;
    logic                cpl_err_q, cpl_err_d;
    logic [CNT_BITS-1:0] cred_q [N_CH];
    logic [CNT_BITS-1:0] cred_d [N_CH];

    logic [N_CH-1:0]     eligible;
    logic                any_elig;
    logic [CH_BITS-1:0]  sel;
    logic [REQ_BITS-1:0] sel_data;
    logic                slot_free;
    logic                grant;
    logic                grant_ctl;
    logic                cpl_ok;

    // A ctl=1 request may only go out while its channel still holds a credit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CH; i++) begin
            eligible[i] = s_valid[i] && (!s_ctl[i] || (cred_q[i] != '0));
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin : rr_select
        logic [CH_BITS:0] idx;
        any_elig = 1'b0;
        sel      = '0;
        idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, rr_ptr_q} + (CH_BITS + 1)'(k);
            if (idx >= N_CH_EXT) begin
                idx = idx - N_CH_EXT;
            end
            if (!any_elig && eligible[idx[CH_BITS-1:0]]) begin
                any_elig = 1'b1;
                sel      = idx[CH_BITS-1:0];
            end
        end
    end

    assign sel_data  = s_data[sel*REQ_BITS +: REQ_BITS];
    assign slot_free = !m_valid_q || m_ready;
    assign grant     = slot_free && any_elig;
    assign grant_ctl = grant && s_ctl[sel];
    assign cpl_ok    = cpl_valid && ({1'b0, cpl_vfid} < N_CH_EXT);
    assign rr_ptr_d  = !grant ? rr_ptr_q : ((sel == LAST_CH) ? '0 : sel + CH_BITS'(1));

    // s_ready is forced low while reset is asserted, even though the slot reads as free.
    always_comb begin
        s_ready = '0;
        if (grant && aresetn) begin
            s_ready[sel] = 1'b1;
        end
    end

    always_comb begin : credit_next
        logic dec;
        logic inc;
        cpl_err_d = cpl_err_q;
        dec       = 1'b0;
        inc       = 1'b0;
        if (cpl_valid && !cpl_ok) begin
            cpl_err_d = 1'b1;
        end
        for (int i = 0; i < N_CH; i++) begin
            dec       = grant_ctl && (sel == CH_BITS'(i));
            inc       = cpl_ok && (cpl_vfid == CH_BITS'(i));
            cred_d[i] = cred_q[i];
            if (inc && !dec && (cred_q[i] == CRED_FULL)) begin
                cpl_err_d = 1'b1;
            end else if (dec && !inc) begin
                cred_d[i] = cred_q[i] - CNT_BITS'(1);
            end else if (inc && !dec) begin
                cred_d[i] = cred_q[i] + CNT_BITS'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ctl_q   <= 1'b0;
            m_vfid_q  <= '0;
            cpl_err_q <= 1'b0;
            // NOTE: the credit array is live control state, so it is reset element by element to full.
            for (int i = 0; i < N_CH; i++) begin
                cred_q[i] <= CRED_FULL;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cpl_err_q <= cpl_err_d;
            for (int i = 0; i < N_CH; i++) begin
                cred_q[i] <= cred_d[i];
            end
            if (slot_free) begin
                m_valid_q <= any_elig;
                if (any_elig) begin
                    m_data_q <= sel_data;
                    m_ctl_q  <= s_ctl[sel];
                    m_vfid_q <= sel;
                end
            end
        end
    end

    always_comb begin
        credits = '0;
        for (int i = 0; i < N_CH; i++) begin
            credits[i*CNT_BITS +: CNT_BITS] = cred_q[i];
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ctl   = m_ctl_q;
    assign m_vfid  = m_vfid_q;
    assign cpl_err = cpl_err_q;

endmodule
